// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide sequencer.
package mdu_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS_A,
        ST_ABS_B,
        ST_ITER,
        ST_FIX_LO,
        ST_FIX_HI,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// Borrows the parent's 32-bit adder whenever busy is high.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int ITER = ITER_COUNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        divz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_s,
    input  logic [1:0]  add_cout
);

    localparam logic [5:0] LAST = 6'(ITER - 1);

    mdu_state_e  state, state_n;
    logic [31:0] acc_hi, acc_hi_n;
    logic [31:0] acc_lo, acc_lo_n;
    logic [31:0] dsr, dsr_n;
    logic [5:0]  cnt, cnt_n;
    logic [1:0]  op_q, op_q_n;
    logic        neg_q, neg_q_n;
    logic        neg_r, neg_r_n;
    logic        cy, cy_n;
    logic        divz_n;

    logic        is_div, is_sgn, fix_hi_en;
    logic        accept, q_bit;
    logic [31:0] r_sh;
    logic        unused_cin31;

    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign is_sgn    = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign fix_hi_en = is_div ? neg_r : neg_q;
    assign r_sh      = {acc_hi[30:0], acc_lo[31]};
    assign q_bit     = acc_hi[31] | add_cout[1];
    assign accept    = (state == ST_IDLE) && start && !abort;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign unused_cin31 = add_cout[0];

    // Adder operands depend only on registered state, never on add_s.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state)
            ST_ABS_A: begin
                if (acc_lo[31]) begin
                    add_a   = ~acc_lo;
                    add_cin = 1'b1;
                end
            end
            ST_ABS_B: begin
                if (dsr[31]) begin
                    add_a   = ~dsr;
                    add_cin = 1'b1;
                end
            end
            ST_ITER: begin
                if (is_div) begin
                    add_a   = r_sh;
                    add_b   = ~dsr;
                    add_cin = 1'b1;
                end else begin
                    add_a = acc_hi;
                    add_b = acc_lo[0] ? dsr : '0;
                end
            end
            ST_FIX_LO: begin
                if (neg_q) begin
                    add_a   = ~acc_lo;
                    add_cin = 1'b1;
                end
            end
            ST_FIX_HI: begin
                if (fix_hi_en) begin
                    add_a   = ~acc_hi;
                    add_cin = is_div | cy;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        dsr_n    = dsr;
        cnt_n    = cnt;
        op_q_n   = op_q;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        cy_n     = cy;
        divz_n   = divz;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_q_n   = op;
                    acc_lo_n = opa;
                    dsr_n    = opb;
                    acc_hi_n = '0;
                    cnt_n    = '0;
                    neg_q_n  = 1'b0;
                    neg_r_n  = 1'b0;
                    cy_n     = 1'b0;
                    divz_n   = op[1] & (opb == '0);
                    state_n  = (op == OP_MULT || op == OP_DIV)
                             ? ST_ABS_A : ST_ITER;
                end
            end
            ST_ABS_A: begin
                neg_q_n = acc_lo[31] ^ dsr[31];
                neg_r_n = is_div & acc_lo[31];
                if (acc_lo[31])
                    acc_lo_n = add_s;
                state_n = ST_ABS_B;
            end
            ST_ABS_B: begin
                if (dsr[31])
                    dsr_n = add_s;
                state_n = ST_ITER;
            end
            ST_ITER: begin
                if (is_div) begin
                    acc_hi_n = q_bit ? add_s : r_sh;
                    acc_lo_n = {acc_lo[30:0], q_bit};
                end else begin
                    acc_hi_n = {add_cout[1], add_s[31:1]};
                    acc_lo_n = {add_s[0], acc_lo[31:1]};
                end
                cnt_n = cnt + 6'd1;
                if (cnt == LAST)
                    state_n = is_sgn ? ST_FIX_LO : ST_DONE;
            end
            ST_FIX_LO: begin
                // cy carries the low-word negate into the high word
                if (neg_q) begin
                    acc_lo_n = add_s;
                    cy_n     = add_cout[1];
                end
                state_n = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                if (fix_hi_en)
                    acc_hi_n = add_s;
                state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE)
            state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc_hi <= '0;
            acc_lo <= '0;
            dsr    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cy     <= 1'b0;
            divz   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_n;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            dsr    <= dsr_n;
            cnt    <= cnt_n;
            op_q   <= op_q_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            cy     <= cy_n;
            divz   <= divz_n;
            if (state_n == ST_DONE) begin
                hi <= acc_hi_n;
                lo <= acc_lo_n;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: random and directed checks of mdu_ctrl against
// a 64-bit arithmetic reference model and a behavioural adder.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        abort = 1'b0;
    logic        busy, done, divz;
    logic [31:0] hi, lo;
    logic [31:0] add_a, add_b, add_s;
    logic        add_cin;
    logic [1:0]  add_cout;

    logic [32:0] sum33;
    logic [31:0] low31;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .divz     (divz),
        .hi       (hi),
        .lo       (lo),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    always #5 clk = ~clk;

    // the parent's shared adder
    assign sum33 = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign low31 = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + {31'b0, add_cin};
    assign add_s = sum33[31:0];
    assign add_cout = {sum33[32], low31[31]};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_MULT:  r = 64'(sa * sb);
            OP_DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default:  r = (b == 0) ? 64'b0 : {32'(sa % sb), 32'(sa / sb)};
        endcase
        return r;
    endfunction

    // reference model: phase = cycles since the accepting edge
    int          m_phase, m_lat;
    logic [63:0] m_res;
    logic        m_divz, m_known;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_lat   <= 0;
            m_res   <= '0;
            m_divz  <= 1'b0;
            m_known <= 1'b1;
            m_op    <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else if (m_phase == 0) begin
            if (start && !abort) begin
                m_op    <= op;
                m_a     <= opa;
                m_b     <= opb;
                m_divz  <= op[1] && (opb == 0);
                m_lat   <= op[0] ? 37 : 33;
                m_phase <= 1;
            end
        end else if (abort || m_phase == m_lat) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 == m_lat) begin
                m_res   <= ref_res(m_op, m_a, m_b);
                m_known <= !(m_op == OP_DIV && m_b == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_phase != 0 && m_phase == m_lat));
            chk("divz", 64'(divz), 64'(m_divz));
            if (m_known)
                chk("hilo", {hi, lo}, m_res);
            if (m_phase == 0 || m_phase == m_lat)
                chk("adder_idle", {31'b0, add_cin, add_b, add_a}, 64'b0);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        int w;
        start = 1'b1;
        op = o;
        opa = a;
        opb = b;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(busy && !done) && w < 4);
        if (!(busy && !done))
            chk("accept", 64'(busy), 64'd1);
        start = 1'b0;
        op = 2'($urandom);
        opa = $urandom;
        opb = $urandom;
        lat = 1;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!done)
            chk("done_timeout", 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h80000000;
            4: v = 32'h7FFFFFFF;
            5: v = 32'($urandom_range(0, 15));
            6: v = -32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divz", 64'(divz), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_adder", {31'b0, add_cin, add_b, add_a}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("multu_lat", 64'(lat), 64'd33);
        chk("multu_ff", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat);
        chk("mult_lat", 64'(lat), 64'd37);
        chk("mult_m3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(OP_MULT, 32'h80000000, 32'h80000000, lat);
        chk("mult_min2", {hi, lo}, 64'h40000000_00000000);
        run_op(OP_DIVU, 32'd100, 32'd7, lat);
        chk("divu_lat", 64'(lat), 64'd33);
        chk("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIVU, 32'd5, 32'd0, lat);
        chk("divu_z_flag", 64'(divz), 64'd1);
        chk("divu_5_0", {hi, lo}, 64'h00000005_FFFFFFFF);
        run_op(OP_DIVU, 32'd6, 32'd3, lat);
        chk("divu_nz_flag", 64'(divz), 64'd0);
        chk("divu_6_3", {hi, lo}, 64'h00000000_00000002);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
        run_op(OP_DIV, 32'd9, 32'd0, lat);
        chk("div_z_flag", 64'(divz), 64'd1);
        run_op(OP_MULTU, 32'd3, 32'd5, lat);
        chk("multu_3_5", {hi, lo}, 64'h00000000_0000000F);

        // abort in cycle 10; a start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = OP_MULT; opa = 32'h1234; opb = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_DIVU; opa = 32'd77; opb = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'h00000000_0000000F);
        chk("abort_divz", 64'(divz), 64'd0);
        run_op(OP_MULT, 32'hFFFFFFF9, 32'd6, lat);
        chk("post_abort_lat", 64'(lat), 64'd37);
        chk("post_abort", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);

        // asynchronous reset in the middle of ITER
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; opa = 32'hDEADBEEF; opb = 32'h12345;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_adder", {31'b0, add_cin, add_b, add_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'h12345678, 32'd9, lat);
        chk("post_rst", {hi, lo}, 64'h00000000_A3D70A38);

        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                start = 1'b1;
                op = 2'($urandom);
                opa = pick();
                opb = pick();
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end else begin
                run_op(2'($urandom), pick(), pick(), lat);
            end
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
